// File: rtl/probe_capture_rdout.sv
// Purpose : captures DEPTH trigger-qualified probe samples, then streams them out.
// Latency : first beat 1 cycle after READOUT entry, then 1 beat/cycle.
// Backpr. : m_valid/m_data/m_last hold while m_ready=0; no beats lost.
//
// Optional build macro: PROBE_CAPTURE_TS_EN (timestamp header beat).
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   arm, abort             start capture from IDLE / return to IDLE
//   trig, smp_en, smp_data trigger, sample qualifier, probe sample
//   m_data, m_valid,       readout stream (valid/ready)
//   m_ready, m_last
//   busy                   high in ARMED, CAPTURE, READOUT
//   done                   one-cycle pulse after the last beat is accepted
module probe_capture_rdout #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic              smp_en,
  input  logic [DATA_W-1:0] smp_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
`ifdef PROBE_CAPTURE_TS_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(DEPTH + HDR);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH + HDR - 1);
  localparam logic [CNT_W-1:0] WR_FINAL = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          fire;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          ld;
  logic [AW-1:0] rd_addr;
  logic          last_acc;

  // Trigger only counts when it coincides with a qualified sample.
  assign fire     = (state == ARMED) && trig && smp_en;
  assign wr_en    = fire || ((state == CAPTURE) && smp_en);
  assign wr_addr  = fire ? '0 : wr_cnt[AW-1:0];
  // Load the output register whenever it is empty or being drained this
  // cycle; the RAM read and the output register are the same stage, which
  // keeps the stream gap-free without a separate skid entry.
  assign ld       = (state == READOUT) && (!m_valid || m_ready) && (rd_cnt < TOTAL);
  assign rd_addr  = AW'(rd_cnt - CNT_W'(HDR));
  assign last_acc = (state == READOUT) && m_valid && m_ready && m_last;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm) state_nx = ARMED;
      ARMED:   if (fire) state_nx = CAPTURE;
      CAPTURE: if (smp_en && (wr_cnt == WR_FINAL)) state_nx = READOUT;
      READOUT: if (last_acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= smp_data;
  end

`ifdef PROBE_CAPTURE_TS_EN
  // The latched value equals the number of rising edges after reset release
  // that precede the trigger edge (trigger on edge N after release -> N-1).
  logic [31:0] cyc_cnt;
  logic [31:0] ts_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ts_q    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (fire) ts_q <= cyc_cnt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last_acc && !abort;
      if (state_nx == IDLE) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        if (fire) wr_cnt <= CNT_W'(1);
        else if (wr_en) wr_cnt <= wr_cnt + CNT_W'(1);
        if (ld) rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (abort) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else if (ld) begin
        m_valid <= 1'b1;
        m_last  <= (rd_cnt == LAST_IDX);
`ifdef PROBE_CAPTURE_TS_EN
        m_data  <= (rd_cnt == '0) ? DATA_W'(ts_q) : mem[rd_addr];
`else
        m_data  <= mem[rd_addr];
`endif
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_probe_capture_rdout.sv
// Purpose : directed self-checking bench for probe_capture_rdout (DEPTH=8).
// Latency : checks first beat within 2 cycles of READOUT, then 1 beat/cycle.
// Backpr. : drives m_ready patterns and checks outputs hold while stalled.
module tb_probe_capture_rdout;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
`ifdef PROBE_CAPTURE_TS_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              trig = 1'b0;
  logic              smp_en = 1'b0;
  logic [DATA_W-1:0] smp_data = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              chk_hdr = 1'b0;
  logic [DATA_W-1:0] exp_hdr = '0;

  probe_capture_rdout #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig),
    .smp_en(smp_en), .smp_data(smp_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm;
    arm = 1'b1;
    tick;
    arm = 1'b0;
    chk("busy_after_arm", busy, 1);
  endtask

  // Expects ARMED; trigger on the first sample, continuous smp_en afterwards.
  task automatic fire_and_fill(input logic [DATA_W-1:0] base);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      trig = (i == 0);
      smp_en = 1'b1;
      smp_data = base + DATA_W'(i);
      exp_q.push_back(base + DATA_W'(i));
      tick;
    end
    trig = 1'b0;
    smp_en = 1'b0;
  endtask

  // pat 0: m_ready=1 always; pat 1: 1,0,0,1 repeating.
  // abort_after >= 0: pulse abort once that many beats were accepted.
  task automatic run_readout(input int pat, input int abort_after);
    int got;
    int cyc;
    int first;
    int total;
    logic fin;
    logic rdy;
    logic hold_v;
    logic hold_l;
    logic [DATA_W-1:0] hold_d;
    got = 0; cyc = 0; first = -1; fin = 1'b0;
    hold_v = 1'b0; hold_l = 1'b0; hold_d = '0;
    total = exp_q.size() + HDR;
    while (!fin && cyc < 200) begin
      if (abort_after >= 0 && got == abort_after) begin
        m_ready = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_valid", m_valid, 0);
        chk("abort_last", m_last, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick;
        chk("abort_done_later", done, 0);
        chk("abort_valid_later", m_valid, 0);
        return;
      end
      rdy = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      m_ready = rdy;
      if (hold_v) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hold_d);
        chk("stall_last", m_last, hold_l);
      end
      if (m_valid && first < 0) begin
        first = cyc;
        chk("first_latency_le2", (first <= 2), 1);
      end
      if (m_valid && rdy) begin
        if (HDR != 0 && got == 0) begin
          if (chk_hdr) chk("hdr_beat", m_data, exp_hdr);
        end else if (got - HDR >= exp_q.size()) begin
          chk("extra_beat", got, total - 1);
        end else begin
          chk("beat_data", m_data, exp_q[got - HDR]);
        end
        chk("beat_last", m_last, (got == total - 1));
        got++;
        if (m_last) fin = 1'b1;
      end
      hold_v = m_valid && !rdy;
      hold_d = m_data;
      hold_l = m_last;
      tick;
      cyc++;
    end
    chk("readout_finished", fin, 1);
    chk("beat_count", got, total);
    chk("done_pulse", done, 1);
    chk("busy_fall", busy, 0);
    chk("valid_after_last", m_valid, 0);
    m_ready = 1'b0;
    tick;
    chk("done_single", done, 0);
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Test 1: trigger on edge 51 after reset release; header (if built) = 0x32.
    rst_n = 1'b1;
    do_arm;
    repeat (49) tick;
    chk("armed_waiting", busy, 1);
    fire_and_fill(32'h100);
    chk("readout_entry_valid", m_valid, 0);
    chk_hdr = 1'b1;
    exp_hdr = 32'h32;
    run_readout(0, -1);
    chk_hdr = 1'b0;

    // Test 2: trig only on an unqualified cycle first, then smp_en toggling.
    do_arm;
    exp_q.delete();
    smp_en = 1'b1; trig = 1'b0; smp_data = 32'h200; tick;
    smp_en = 1'b0; trig = 1'b1; smp_data = 32'h201; tick;
    smp_en = 1'b1; trig = 1'b0; smp_data = 32'h202; tick;
    smp_en = 1'b0; trig = 1'b0; smp_data = 32'h203; tick;
    chk("no_false_fire_valid", m_valid, 0);
    smp_en = 1'b1; trig = 1'b1; smp_data = 32'h204; tick;
    exp_q.push_back(32'h204);
    trig = 1'b0;
    for (int i = 0; i < 14; i++) begin
      smp_en = (i % 2 == 1);
      smp_data = 32'h205 + 32'(i);
      if (i % 2 == 1) exp_q.push_back(32'h205 + 32'(i));
      tick;
    end
    smp_en = 1'b0;
    run_readout(0, -1);

    // Test 3: back-pressure pattern 1,0,0,1.
    do_arm;
    fire_and_fill(32'h300);
    run_readout(1, -1);

    // Test 4: abort after 3 accepted beats, then a clean full capture.
    do_arm;
    fire_and_fill(32'h380);
    run_readout(0, 3);
    do_arm;
    fire_and_fill(32'h400);
    run_readout(0, -1);

    // Test 5: asynchronous reset during CAPTURE.
    do_arm;
    for (int i = 0; i < 4; i++) begin
      trig = (i == 0); smp_en = 1'b1; smp_data = 32'h500 + 32'(i);
      tick;
    end
    trig = 1'b0;
    smp_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_last", m_last, 0);
    chk("arst_data", m_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_arst_busy", busy, 0);

    // Test 6: arm during READOUT is ignored.
    do_arm;
    fire_and_fill(32'h600);
    arm = 1'b1;
    m_ready = 1'b0;
    tick;
    arm = 1'b0;
    chk("arm_in_readout_busy", busy, 1);
    chk("arm_in_readout_valid", m_valid, 1);
    run_readout(0, -1);
    chk("idle_after_ignored_arm", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
